rom_fetch_seq: RTL and testbench
================================

Name: rom_fetch_seq

Overview:
- Control-side sequencer for the serial quad-ROM bus.
- Generates word timing: 56 bit-times per word cycle, with the `sync` frame marker.
- Each word: shifts the next 8-bit ROM address out on `ia`, deserialises the 10-bit instruction returned on `is`, and presents it to the instruction decoder.
- Holds the program counter and a one-level return register, and resolves increment, branch, call, return and halt once per word.

Parameters:
- WORD_LEN, 56: bit-times per word cycle; the counter runs 0..WORD_LEN-1.
- ADR_W, 8: ROM address width within a page.
- INST_W, 10: instruction width.
- ADR_START, 19: first bit-time of the serial address field.
- INST_START, 45: first bit-time of the serial instruction field.

Ports:
- cph1  in  1  bit clock; all state updates on its rising edge.
- pon_n  in  1  asynchronous active-low reset.
- run  in  1  1 = advance PC at end of word; 0 = hold PC, re-fetch the same address.
- br_valid  in  1  branch request, sampled at the end of bit-time 55.
- br_addr  in  ADR_W  branch target.
- br_call  in  1  with br_valid: save return address.
- br_ret  in  1  return request; load PC from the return register.
- is  in  1  serial instruction from the ROMs, LSB first.
- sync  out  1  active-low word marker, low exactly during bit-time 0.
- ia  out  1  serial address to the ROMs, LSB first.
- bit_cnt  out  6  current bit-time, 0..55.
- inst  out  INST_W  last fetched instruction.
- inst_pc  out  ADR_W  address that `inst` was fetched from.
- inst_valid  out  1  high for the whole of bit-time 55 when a new instruction is presented.

Behaviour:
- Reset (pon_n low, async), all registered:
  - bit_cnt=0, sync=0, ia=0
  - pc=0, ret_r=0
  - inst=0, inst_pc=0, inst_valid=0
  - Takes effect immediately, including mid-word. On release, word timing restarts at bit-time 0 and the first fetch is address 0.
- Bit counter:
  - Increments every cph1 edge and wraps 55→0.
  - No other source alters it.
- sync: registered; 0 while bit_cnt==0, 1 otherwise. A downstream ROM counter released by sync therefore tracks bit_cnt exactly.
- ia: registered.
  - During bit-times 19..26, ia = pc[bit_cnt-19] (pc bit 0 at bit-time 19).
  - 0 at all other bit-times.
  - pc is stable for the entire address field; it changes only at the end of bit-time 55.
- Instruction capture:
  - `is` is sampled at the end of bit-times 45..54 into a shift register, bit j at bit-time 45+j.
  - `is` at all other bit-times (e.g. the ROM's bit-11 pulse) is ignored.
- Presentation (edge ending bit-time 54):
  - inst ← assembled shift register; inst_pc ← pc.
  - inst_valid ← run.
  - inst_valid clears at the edge ending bit-time 55, so it is one bit-time wide.
  - inst/inst_pc hold until the next word's bit-time 54 edge.
- Next-address resolution (edge ending bit-time 55), first match wins:
  1. run=0: pc holds; br_* ignored; ret_r holds.
  2. br_ret=1: pc ← ret_r (br_valid/br_call ignored).
  3. br_valid=1: pc ← br_addr; if br_call, ret_r ← pc+1 (mod 256).
  4. otherwise: pc ← pc+1, wrapping 255→0.
  - br_call without br_valid has no effect.
  - A second call overwrites ret_r; there is no stack and no overflow flag.
- Latency:
  - Decoder drives br_* combinationally from inst during bit-time 55.
  - The resulting address is shifted out in bit-times 19..26 of the next word.
  - The fetched instruction is presented at bit-time 55 of that word: exactly one word cycle (56 cph1) per instruction.
- Page selection is handled by the ROMs; this block treats addresses as page-relative.

Decomposition:
- Package rom_seq_pkg holds:
  - constants WORD_LEN, ADR_START, ADR_END=26, INST_START, INST_END=54, EOW=55
  - typedefs rom_adr_t (8b), rom_inst_t (10b), bit_time_t (6b)
- One sub-module, rom_bit_timer, holds the bit counter and sync register. It exposes:
  - bit_cnt
  - one-hot strobes: is_adr_field, is_inst_field, is_t54, is_eow
- The PC/return logic and the serdes stay in rom_fetch_seq.

Test Plan:
- Reset, then free run with `is` driven from a model ROM (inst = addr XOR 0x155) → sync low only at bit_cnt 0; ia carries 0x00, 0x01, 0x02… LSB-first on bit-times 19..26; inst_valid at bit-time 55 with inst_pc=n, inst=n^0x155.
- pc=0xFF, no branch → next address 0x00 (wrap), inst_pc=0x00 next word.
- At inst_pc=0x10: br_valid=1, br_addr=0x80, br_call=1; later br_ret=1 → fetch 0x80, then 0x81..; on return, fetch 0x11. Two nested calls → return goes to the second call's pc+1.
- br_ret and br_valid (0x40) asserted together → return-register address wins, not 0x40.
- run=0 for 3 words → ia repeats the same address, inst_valid stays 0, br_* ignored; run=1 resumes at pc+1.
- pon_n pulsed low at bit-time 30 of a word → all outputs immediately 0; after release, bit_cnt counts from 0 and the first fetch is address 0x00.

Source files
------------

// File: rtl/rom_seq_pkg.sv
// Shared constants and types for the serial quad-ROM fetch sequencer.
// All bit-time positions are relative to the 56-bit word cycle.
package rom_seq_pkg;

  localparam int unsigned WORD_LEN   = 56;
  localparam int unsigned ADR_W      = 8;
  localparam int unsigned INST_W     = 10;
  localparam int unsigned BIT_W      = 6;
  localparam int unsigned ADR_START  = 19;
  localparam int unsigned ADR_END    = 26;
  localparam int unsigned INST_START = 45;
  localparam int unsigned INST_END   = 54;
  localparam int unsigned EOW        = WORD_LEN - 1;

  typedef logic [ADR_W-1:0]  rom_adr_t;
  typedef logic [INST_W-1:0] rom_inst_t;
  typedef logic [BIT_W-1:0]  bit_time_t;

  // Source of the next program counter, chosen once per word.
  typedef enum logic [1:0] {
    NXT_HOLD,
    NXT_RET,
    NXT_BRANCH,
    NXT_INC
  } nxt_src_e;

  // Priority: halted, then return, then branch/call, then sequential.
  function automatic nxt_src_e resolve_src(input logic run,
                                           input logic br_ret,
                                           input logic br_valid);
    nxt_src_e src;
    if (!run) begin
      src = NXT_HOLD;
    end else if (br_ret) begin
      src = NXT_RET;
    end else if (br_valid) begin
      src = NXT_BRANCH;
    end else begin
      src = NXT_INC;
    end
    return src;
  endfunction

endpackage

// File: rtl/rom_bit_timer.sv
// Word timing for the ROM bus: free-running bit counter, registered sync,
// and decoded strobes used by the fetch sequencer.
module rom_bit_timer
  import rom_seq_pkg::*;
(
  input  logic      cph1,
  input  logic      pon_n,
  output bit_time_t bit_cnt,
  output logic      sync,
  output logic      is_adr_field,
  output logic      is_inst_field,
  output logic      is_t54,
  output logic      is_eow
);

  // Counter wraps at end of word; sync is low exactly while the count is 0.
  always_ff @(posedge cph1 or negedge pon_n) begin
    if (!pon_n) begin
      bit_cnt <= '0;
      sync    <= 1'b0;
    end else begin
      bit_cnt <= is_eow ? '0 : bit_cnt + bit_time_t'(1);
      sync    <= !is_eow;
    end
  end

  // is_adr_field leads the address field by one bit-time, so a register
  // loaded under it presents address bits on 19..26.
  always_comb begin
    is_eow        = (bit_cnt == bit_time_t'(EOW));
    is_t54        = (bit_cnt == bit_time_t'(INST_END));
    is_inst_field = (bit_cnt >= bit_time_t'(INST_START)) &&
                    (bit_cnt <= bit_time_t'(INST_END));
    is_adr_field  = (bit_cnt >= bit_time_t'(ADR_START - 1)) &&
                    (bit_cnt <= bit_time_t'(ADR_END - 1));
  end

endmodule

// File: rtl/rom_fetch_seq.sv
// Control-side sequencer for the serial quad-ROM bus: shifts out the PC,
// deserialises the returned instruction and resolves the next address.
module rom_fetch_seq
  import rom_seq_pkg::*;
(
  input  logic              cph1,
  input  logic              pon_n,
  input  logic              run,
  input  logic              br_valid,
  input  logic [ADR_W-1:0]  br_addr,
  input  logic              br_call,
  input  logic              br_ret,
  input  logic              is,
  output logic              sync,
  output logic              ia,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic [INST_W-1:0] inst,
  output logic [ADR_W-1:0]  inst_pc,
  output logic              inst_valid
);

  logic is_adr_field;
  logic is_inst_field;
  logic is_t54;
  logic is_eow;

  rom_adr_t              pc;
  rom_adr_t              ret_r;
  rom_adr_t              pc_nxt;
  rom_adr_t              ret_nxt;
  rom_adr_t              pc_inc;
  nxt_src_e              nxt_src;
  logic [INST_W-2:0]     inst_sr;
  rom_inst_t             inst_asm;
  logic [2:0]            adr_idx;
  logic                  ia_nxt;

  rom_bit_timer u_timer (
    .cph1          (cph1),
    .pon_n         (pon_n),
    .bit_cnt       (bit_cnt),
    .sync          (sync),
    .is_adr_field  (is_adr_field),
    .is_inst_field (is_inst_field),
    .is_t54        (is_t54),
    .is_eow        (is_eow)
  );

  // Next-address resolution; only committed at the end of bit-time 55.
  always_comb begin
    pc_inc  = pc + rom_adr_t'(1);
    pc_nxt  = pc;
    ret_nxt = ret_r;
    nxt_src = resolve_src(run, br_ret, br_valid);
    unique case (nxt_src)
      NXT_HOLD: begin
        pc_nxt = pc;
      end
      NXT_RET: begin
        pc_nxt = ret_r;
      end
      NXT_BRANCH: begin
        pc_nxt = br_addr;
        if (br_call) begin
          ret_nxt = pc_inc;
        end
      end
      NXT_INC: begin
        pc_nxt = pc_inc;
      end
      default: begin
        pc_nxt = pc;
      end
    endcase
  end

  // Serial address bit for the upcoming bit-time, LSB first.
  always_comb begin
    adr_idx = 3'(bit_cnt - bit_time_t'(ADR_START - 1));
    ia_nxt  = is_adr_field ? pc[adr_idx] : 1'b0;
  end

  // Incoming bit lands in the MSB; the earliest bit ends up at bit 0.
  always_comb begin
    inst_asm = {is, inst_sr};
  end

  always_ff @(posedge cph1 or negedge pon_n) begin
    if (!pon_n) begin
      pc    <= '0;
      ret_r <= '0;
    end else if (is_eow) begin
      pc    <= pc_nxt;
      ret_r <= ret_nxt;
    end
  end

  always_ff @(posedge cph1 or negedge pon_n) begin
    if (!pon_n) begin
      ia <= 1'b0;
    end else begin
      ia <= ia_nxt;
    end
  end

  always_ff @(posedge cph1 or negedge pon_n) begin
    if (!pon_n) begin
      inst_sr <= '0;
    end else if (is_inst_field) begin
      inst_sr <= inst_asm[INST_W-1:1];
    end
  end

  // Presentation to the decoder: loaded at end of 54, strobe cleared at end of 55.
  always_ff @(posedge cph1 or negedge pon_n) begin
    if (!pon_n) begin
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else if (is_t54) begin
      inst       <= inst_asm;
      inst_pc    <= pc;
      inst_valid <= run;
    end else if (is_eow) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom_fetch_seq.sv
// Bench for rom_fetch_seq: model ROM on the serial bus, word-level reference
// model checked every bit-time, plus literal pins on presented instructions.
module tb_rom_fetch_seq;

  logic       cph1     = 1'b0;
  logic       pon_n    = 1'b0;
  logic       run      = 1'b0;
  logic       br_valid = 1'b0;
  logic [7:0] br_addr  = 8'h00;
  logic       br_call  = 1'b0;
  logic       br_ret   = 1'b0;
  logic       is       = 1'b0;
  logic       sync;
  logic       ia;
  logic [5:0] bit_cnt;
  logic [9:0] inst;
  logic [7:0] inst_pc;
  logic       inst_valid;

  always #5 cph1 = ~cph1;

  rom_fetch_seq dut (
    .cph1       (cph1),
    .pon_n      (pon_n),
    .run        (run),
    .br_valid   (br_valid),
    .br_addr    (br_addr),
    .br_call    (br_call),
    .br_ret     (br_ret),
    .is         (is),
    .sync       (sync),
    .ia         (ia),
    .bit_cnt    (bit_cnt),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: position in word, PC, return register, presentation.
  int         m_pos;
  logic [7:0] m_pc;
  logic [7:0] m_ret;
  logic [9:0] m_inst;
  logic [7:0] m_inst_pc;
  logic       m_valid;
  logic [7:0] rom_adr;

  typedef struct {
    bit         run;
    bit         bv;
    bit         bc;
    bit         br;
    logic [7:0] ba;
    int         exp_pc;
    int         exp_inst;
    bit         exp_valid;
  } cmd_t;

  cmd_t cmds[20];

  function automatic cmd_t mk(input bit r, input bit bv, input bit bc, input bit br,
                              input logic [7:0] ba, input int epc, input int einst,
                              input bit ev);
    cmd_t c;
    c.run = r; c.bv = bv; c.bc = bc; c.br = br; c.ba = ba;
    c.exp_pc = epc; c.exp_inst = einst; c.exp_valid = ev;
    return c;
  endfunction

  function automatic logic [9:0] rom_word(input logic [7:0] a);
    return {2'b00, a} ^ 10'h155;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s t=%0t pos=%0d got=%0h exp=%0h", name, $time, m_pos, got, exp);
    end
  endtask

  task automatic check_outputs();
    int exp_ia;
    exp_ia = 0;
    if (m_pos >= 19 && m_pos <= 26) exp_ia = int'(m_pc[m_pos-19]);
    chk("bit_cnt",    int'(bit_cnt),    m_pos);
    chk("sync",       int'(sync),       (m_pos != 0) ? 1 : 0);
    chk("ia",         int'(ia),         exp_ia);
    chk("inst_valid", int'(inst_valid), int'(m_valid));
    chk("inst",       int'(inst),       int'(m_inst));
    chk("inst_pc",    int'(inst_pc),    int'(m_inst_pc));
  endtask

  task automatic model_reset();
    m_pos = 0; m_pc = 8'h00; m_ret = 8'h00;
    m_inst = 10'h000; m_inst_pc = 8'h00; m_valid = 1'b0;
  endtask

  // Asynchronous reset in the middle of a word; outputs must clear at once.
  task automatic mid_reset();
    #1 pon_n = 1'b0;
    #1;
    chk("rst_bit_cnt",    int'(bit_cnt),    0);
    chk("rst_sync",       int'(sync),       0);
    chk("rst_ia",         int'(ia),         0);
    chk("rst_inst",       int'(inst),       0);
    chk("rst_inst_pc",    int'(inst_pc),    0);
    chk("rst_inst_valid", int'(inst_valid), 0);
    @(posedge cph1);
    @(negedge cph1);
    #1;
    chk("rst_hold_bit_cnt", int'(bit_cnt), 0);
    model_reset();
    pon_n = 1'b1;
  endtask

  // One word cycle, entered and left just after a falling edge.
  task automatic run_word(input cmd_t c, input int rst_at);
    logic [9:0] w;
    for (int p = 0; p < 56; p++) begin
      check_outputs();
      if (m_pos == rst_at) begin
        mid_reset();
        return;
      end
      if (m_pos == 55 && c.exp_pc >= 0) begin
        chk("pin_inst_pc", int'(inst_pc),    c.exp_pc);
        chk("pin_inst",    int'(inst),       c.exp_inst);
        chk("pin_valid",   int'(inst_valid), int'(c.exp_valid));
      end
      if (m_pos >= 19 && m_pos <= 26) rom_adr[m_pos-19] = ia;
      run = c.run;
      if (m_pos >= 45 && m_pos <= 54) begin
        w  = rom_word(rom_adr);
        is = w[m_pos-45];
      end else if (m_pos == 11) begin
        is = 1'b1;
      end else begin
        is = 1'($urandom % 2);
      end
      if (m_pos == 55) begin
        br_valid = c.bv; br_call = c.bc; br_ret = c.br; br_addr = c.ba;
      end else begin
        br_valid = 1'b0; br_call = 1'b0; br_ret = 1'b0; br_addr = 8'($urandom);
      end
      @(posedge cph1);
      if (m_pos == 54) begin
        m_inst = rom_word(m_pc); m_inst_pc = m_pc; m_valid = c.run;
      end
      if (m_pos == 55) begin
        m_valid = 1'b0;
        if (!c.run) begin
          m_pc = m_pc;
        end else if (c.br) begin
          m_pc = m_ret;
        end else if (c.bv) begin
          if (c.bc) m_ret = m_pc + 8'd1;
          m_pc = c.ba;
        end else begin
          m_pc = m_pc + 8'd1;
        end
      end
      m_pos = (m_pos + 1) % 56;
      @(negedge cph1);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmds[0]  = mk(1,0,0,0,8'h00, 'h00, 'h155, 1);
    cmds[1]  = mk(1,0,0,0,8'h00, 'h01, 'h154, 1);
    cmds[2]  = mk(1,0,0,0,8'h00, -1,   0,     0);
    cmds[3]  = mk(1,1,0,0,8'hFE, 'h03, 'h156, 1);
    cmds[4]  = mk(1,0,0,0,8'h00, 'hFE, 'h1AB, 1);
    cmds[5]  = mk(1,0,0,0,8'h00, 'hFF, 'h1AA, 1);
    cmds[6]  = mk(1,1,0,0,8'h10, 'h00, 'h155, 1);
    cmds[7]  = mk(1,1,1,0,8'h80, 'h10, 'h145, 1);
    cmds[8]  = mk(1,0,0,0,8'h00, 'h80, 'h1D5, 1);
    cmds[9]  = mk(1,0,0,1,8'h00, 'h81, 'h1D4, 1);
    cmds[10] = mk(1,1,1,0,8'h20, 'h11, 'h144, 1);
    cmds[11] = mk(1,1,1,0,8'h30, 'h20, 'h175, 1);
    cmds[12] = mk(1,0,0,1,8'h00, 'h30, 'h165, 1);
    cmds[13] = mk(1,1,0,1,8'h40, 'h21, 'h174, 1);
    cmds[14] = mk(1,0,1,0,8'h00, 'h21, 'h174, 1);
    cmds[15] = mk(0,1,0,0,8'h50, 'h22, 'h177, 0);
    cmds[16] = mk(0,0,0,1,8'h00, 'h22, 'h177, 0);
    cmds[17] = mk(0,0,0,0,8'h00, 'h22, 'h177, 0);
    cmds[18] = mk(1,0,0,0,8'h00, 'h22, 'h177, 1);
    cmds[19] = mk(1,0,0,0,8'h00, 'h23, 'h176, 1);

    rom_adr = 8'h00;
    model_reset();
    pon_n = 1'b0;
    repeat (3) @(posedge cph1);
    @(negedge cph1);
    #1;
    check_outputs();
    pon_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run_word(cmds[i], (i == 19) ? 30 : -1);
    end
    run_word(mk(1,0,0,0,8'h00, 'h00, 'h155, 1), -1);
    run_word(mk(1,0,0,0,8'h00, 'h01, 'h154, 1), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
